// File: rtl/data_sram_ctrl.sv
// -----------------------------------------------------------------------------
// data_sram_ctrl
//
// Memory-stage load/store sequencer for the mipsel32 pipeline. It takes one
// load or store per handshake from EX/MEM and derives the bus size, byte
// strobes, aligned address and lane-shifted store data. Sub-word, word and
// unaligned (LWL/LWR/SWL/SWR) accesses are supported. It drives a
// single-outstanding SRAM-like bus (addr_ok / data_ok two-phase handshake)
// and returns the raw read word to writeback. Misaligned half/word
// addresses are reported without touching the bus. A pipeline flush kills
// un-issued requests and discards in-flight responses.
//
// Handshake semantics: an access transfers on a rising edge where
// req_valid && req_ready. req_ready depends only on internal state and flush,
// never on req_valid. On the bus side a request transfers on a rising edge
// where data_req && data_addr_ok. Completion is the first edge after that
// with data_data_ok high. data_data_ok at any other time is ignored.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid/req_ready         access handshake from the pipeline
//   req_wr, req_op              1=store; op 0 byte,1 half,2 word,3 LWL/SWL,
//                               4 LWR/SWR, others behave as word
//   req_addr, req_wdata         byte address, unshifted store data (rt)
//   flush                       kill un-issued / discard in-flight access
//   resp_valid/resp_rdata/resp_ale   one-cycle completion pulse, raw load
//                               word (0 for stores), address error flag
//   data_req/wr/size/addr/wstrb/wdata  bus request fields (registered)
//   data_addr_ok, data_rdata, data_data_ok  bus slave responses
//   dbg_state                   current FSM state for observation
// -----------------------------------------------------------------------------
module data_sram_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_ale,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_discard;
  logic        r_is_load;
  logic        r_data_req;
  logic        r_data_wr;
  logic [1:0]  r_data_size;
  logic [31:0] r_data_addr;
  logic [3:0]  r_data_wstrb;
  logic [31:0] r_data_wdata;
  logic        r_resp_valid;
  logic        r_resp_ale;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic        w_misaligned;
  logic [1:0]  w_k;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_discard_next;
  logic        w_resp_fire;
  logic        w_ale_fire;

  assign req_ready = (r_state == S_IDLE) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign w_k       = req_addr[1:0];

  // Request decode: bus fields for the presented access.
  always_comb begin
    w_size       = 2'd2;
    w_addr       = req_addr;
    w_wstrb      = 4'b1111;
    w_wdata      = req_wdata;
    w_misaligned = 1'b0;
    case (req_op)
      3'b000: begin
        w_size  = 2'd0;
        w_wstrb = 4'b0001 << w_k;
        w_wdata = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        w_size       = 2'd1;
        w_wstrb      = w_k[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{req_wdata[15:0]}};
        w_misaligned = w_k[0];
      end
      3'b011: begin
        // SWL: the high bytes of rt land in lanes 0..k
        w_addr  = {req_addr[31:2], 2'b00};
        w_wstrb = 4'b1111 >> (2'd3 - w_k);
        w_wdata = req_wdata >> {(2'd3 - w_k), 3'b000};
      end
      3'b100: begin
        // SWR: the low bytes of rt land in lanes k..3
        w_addr  = {req_addr[31:2], 2'b00};
        w_wstrb = 4'b1111 << w_k;
        w_wdata = req_wdata << {w_k, 3'b000};
      end
      default: begin
        // word and all illegal encodings
        w_misaligned = (w_k != 2'd0);
      end
    endcase
    if (!req_wr) begin
      w_wstrb = 4'b0000;
    end
  end

  // Next-state and response decision.
  always_comb begin
    w_next         = r_state;
    w_discard_next = 1'b0;
    w_resp_fire    = 1'b0;
    w_ale_fire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_resp_fire = 1'b1;
            w_ale_fire  = 1'b1;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (data_addr_ok) begin
          // once the slave took the address, the data phase must be drained
          w_next         = S_WAIT;
          w_discard_next = flush;
        end else if (flush) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          w_next      = S_IDLE;
          w_resp_fire = !(r_discard || flush);
        end else begin
          w_discard_next = r_discard || flush;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_discard    <= 1'b0;
      r_is_load    <= 1'b0;
      r_data_req   <= 1'b0;
      r_data_wr    <= 1'b0;
      r_data_size  <= 2'd0;
      r_data_addr  <= 32'h0;
      r_data_wstrb <= 4'h0;
      r_data_wdata <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_ale   <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_state      <= w_next;
      r_discard    <= w_discard_next;
      r_data_req   <= (w_next == S_REQ);
      r_resp_valid <= w_resp_fire;
      r_resp_ale   <= w_ale_fire;
      r_resp_rdata <= (w_resp_fire && !w_ale_fire && r_is_load) ? data_rdata : 32'h0;
      // bus fields only change on an accepted bus-bound access, so they
      // stay stable for the whole time data_req is high
      if (w_accept && !w_misaligned) begin
        r_is_load    <= !req_wr;
        r_data_wr    <= req_wr;
        r_data_size  <= w_size;
        r_data_addr  <= w_addr;
        r_data_wstrb <= w_wstrb;
        r_data_wdata <= w_wdata;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_ale   = r_resp_ale;
  assign resp_rdata = r_resp_rdata;
  assign data_req   = r_data_req;
  assign data_wr    = r_data_wr;
  assign data_size  = r_data_size;
  assign data_addr  = r_data_addr;
  assign data_wstrb = r_data_wstrb;
  assign data_wdata = r_data_wdata;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_sram_ctrl
//
// Self-checking bench for data_sram_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_data_sram_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_wr, flush;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ale;
  logic [31:0] resp_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [1:0]  dbg_state;

  data_sram_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_ale     (resp_ale),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Lane view of an access: which byte lanes it covers and which rt byte
  // feeds each lane.
  function automatic logic [3:0] strb_of(input logic [2:0] op, input int k);
    int lo, hi;
    logic [3:0] s;
    case (op)
      3'd0:    begin lo = k; hi = k;     end
      3'd1:    begin lo = k; hi = k + 1; end
      3'd3:    begin lo = 0; hi = k;     end
      3'd4:    begin lo = k; hi = 3;     end
      default: begin lo = 0; hi = 3;     end
    endcase
    for (int i = 0; i < 4; i++) s[i] = (i >= lo) && (i <= hi);
    return s;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] op, input int k, input logic [31:0] rt);
    logic [31:0] r;
    int src;
    r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      case (op)
        3'd0:    src = 0;
        3'd1:    src = i % 2;
        3'd3:    src = (i <= k) ? (3 - k + i) : -1;
        3'd4:    src = (i >= k) ? (i - k) : -1;
        default: src = i;
      endcase
      if (src >= 0) r[8*i +: 8] = rt[8*src +: 8];
    end
    return r;
  endfunction

  function automatic logic misal_of(input logic [2:0] op, input logic [31:0] a);
    case (op)
      3'd0, 3'd3, 3'd4: return 1'b0;
      3'd1:             return a[0];
      default:          return a[1:0] != 2'b00;
    endcase
  endfunction

  logic        m_busy, m_taken, m_kill, m_load, m_rv;
  logic        m_fwr;
  logic [1:0]  m_fsize;
  logic [31:0] m_faddr, m_fwdata;
  logic [3:0]  m_fstrb;
  logic [32:0] exp_q[$];   // {ale, rdata} of each expected response

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 1'b0; m_taken = 1'b0; m_kill = 1'b0; m_load = 1'b0; m_rv = 1'b0;
      exp_q.delete();
    end else begin
      m_rv = 1'b0;
      if (!m_busy) begin
        if (req_valid && !flush) begin
          if (misal_of(req_op, req_addr)) begin
            m_rv = 1'b1;
            exp_q.push_back({1'b1, 32'h0});
          end else begin
            m_busy   = 1'b1;
            m_taken  = 1'b0;
            m_kill   = 1'b0;
            m_load   = !req_wr;
            m_fwr    = req_wr;
            m_fsize  = (req_op == 3'd0) ? 2'd0 : (req_op == 3'd1) ? 2'd1 : 2'd2;
            m_faddr  = (req_op == 3'd3 || req_op == 3'd4) ? (req_addr & ~32'h3) : req_addr;
            m_fstrb  = req_wr ? strb_of(req_op, int'(req_addr[1:0])) : 4'h0;
            m_fwdata = wdata_of(req_op, int'(req_addr[1:0]), req_wdata);
          end
        end
      end else if (!m_taken) begin
        if (data_addr_ok) begin
          m_taken = 1'b1;
          m_kill  = flush;
        end else if (flush) begin
          m_busy = 1'b0;
        end
      end else if (data_data_ok) begin
        m_busy = 1'b0;
        if (!(m_kill || flush)) begin
          m_rv = 1'b1;
          exp_q.push_back({1'b0, (m_load ? data_rdata : 32'h0)});
        end
      end else if (flush) begin
        m_kill = 1'b1;
      end
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  logic [32:0] e;
  always @(negedge clk) begin
    if (resetn) begin
      chk1("data_req", data_req, m_busy && !m_taken);
      chk1("req_ready", req_ready, !m_busy && !flush);
      if (m_busy && !m_taken) begin
        chk1 ("data_wr",    data_wr,    m_fwr);
        chk32("data_size",  32'(data_size),  32'(m_fsize));
        chk32("data_addr",  data_addr,  m_faddr);
        chk32("data_wstrb", 32'(data_wstrb), 32'(m_fstrb));
        if (m_fwr) chk32("data_wdata", data_wdata, m_fwdata);
      end
      chk1("resp_valid", resp_valid, m_rv);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got a response, expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk1("resp_ale", resp_ale, e[32]);
          if (!e[32]) chk32("resp_rdata", resp_rdata, e[31:0]);
        end
      end else if (m_rv && exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end
    end
  end

  // ---------------- bus slave driver ----------------
  bit          rand_mode = 1'b0;
  int          addr_delay = 0;
  int          data_delay = 0;
  logic [31:0] fixed_rdata = 32'h0;

  initial begin
    int cnt;
    bit pend, prev_afire, prev_dfire;
    cnt = 0; pend = 0; prev_afire = 0; prev_dfire = 0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        pend = 0; cnt = 0; prev_afire = 0; prev_dfire = 0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
      end else begin
        if (prev_afire) begin pend = 1; cnt = 0; end
        if (prev_dfire) begin pend = 0; cnt = 0; end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (pend) begin
          if (rand_mode ? ($urandom_range(0, 2) == 0) : (cnt >= data_delay)) begin
            data_data_ok = 1'b1;
            data_rdata   = rand_mode ? $urandom : fixed_rdata;
          end else begin
            cnt++;
          end
        end else if (data_req) begin
          if (rand_mode ? ($urandom_range(0, 2) == 0) : (cnt >= addr_delay)) data_addr_ok = 1'b1;
          else cnt++;
        end else begin
          cnt = 0;
          // stray data_ok with nothing outstanding must be ignored
          if (rand_mode && $urandom_range(0, 7) == 0) begin
            data_data_ok = 1'b1;
            data_rdata   = $urandom;
          end
        end
        prev_afire = data_addr_ok && data_req;
        prev_dfire = data_data_ok && pend;
      end
    end
  end

  // ---------------- pipeline driver tasks ----------------
  task automatic send(input logic wr, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    req_wr = wr; req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_ready: got req_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int exp_lat, input logic exp_ale, input logic [31:0] exp_rd);
    int lat;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    chk32({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk1({name, "_ale"}, resp_ale, exp_ale);
    chk32({name, "_rdata"}, resp_rdata, exp_rd);
  endtask

  task automatic check_all_zero(input string name);
    chk1 ({name, "_data_req"},   data_req,   1'b0);
    chk1 ({name, "_data_wr"},    data_wr,    1'b0);
    chk32({name, "_data_size"},  32'(data_size),  32'h0);
    chk32({name, "_data_addr"},  data_addr,  32'h0);
    chk32({name, "_data_wstrb"}, 32'(data_wstrb), 32'h0);
    chk32({name, "_data_wdata"}, data_wdata, 32'h0);
    chk1 ({name, "_resp_valid"}, resp_valid, 1'b0);
    chk1 ({name, "_resp_ale"},   resp_ale,   1'b0);
    chk32({name, "_resp_rdata"}, resp_rdata, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_op = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // SB 0x1002
    send(1'b1, 3'd0, 32'h0000_1002, 32'h0000_00AB);
    @(negedge clk);
    chk1 ("sb_req",   data_req, 1'b1);
    chk1 ("sb_wr",    data_wr,  1'b1);
    chk32("sb_addr",  data_addr, 32'h0000_1002);
    chk32("sb_size",  32'(data_size), 32'h0);
    chk32("sb_wstrb", 32'(data_wstrb), 32'h4);
    chk32("sb_wdata", data_wdata, 32'hABAB_ABAB);
    wait_resp("sb", 2, 1'b0, 32'h0);

    // SWL / SWR 0x2001
    send(1'b1, 3'd3, 32'h0000_2001, 32'h1122_3344);
    @(negedge clk);
    chk32("swl_addr",  data_addr, 32'h0000_2000);
    chk32("swl_wstrb", 32'(data_wstrb), 32'h3);
    chk32("swl_wdata", data_wdata, 32'h0000_1122);
    wait_resp("swl", 2, 1'b0, 32'h0);
    send(1'b1, 3'd4, 32'h0000_2001, 32'h1122_3344);
    @(negedge clk);
    chk32("swr_addr",  data_addr, 32'h0000_2000);
    chk32("swr_wstrb", 32'(data_wstrb), 32'hE);
    chk32("swr_wdata", data_wdata, 32'h2233_4400);
    wait_resp("swr", 2, 1'b0, 32'h0);

    // LW with addr_ok delayed 3 cycles
    addr_delay  = 3;
    fixed_rdata = 32'hDEAD_BEEF;
    send(1'b0, 3'd2, 32'h0000_3000, 32'h0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!data_req) break;
      n++;
      chk32("lw_addr_stable", data_addr, 32'h0000_3000);
    end
    chk32("lw_req_cycles", 32'(n), 32'd4);
    wait_resp("lw", 1, 1'b0, 32'hDEAD_BEEF);
    addr_delay = 0;

    // misaligned LH / SW
    send(1'b0, 3'd1, 32'h0000_4001, 32'h0);
    @(negedge clk);
    chk1("lh_ale_noreq", data_req,   1'b0);
    chk1("lh_ale_valid", resp_valid, 1'b1);
    chk1("lh_ale_flag",  resp_ale,   1'b1);
    chk1("lh_ale_ready", req_ready,  1'b1);
    send(1'b1, 3'd2, 32'h0000_4002, 32'h1234_5678);
    @(negedge clk);
    chk1("sw_ale_noreq", data_req,   1'b0);
    chk1("sw_ale_valid", resp_valid, 1'b1);
    chk1("sw_ale_flag",  resp_ale,   1'b1);

    // flush in REQ before addr_ok
    addr_delay = 5;
    send(1'b0, 3'd2, 32'h0000_5000, 32'h0);
    @(negedge clk);
    chk1("freq_req_before", data_req, 1'b1);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk1("freq_req_after", data_req, 1'b0);
    n = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (resp_valid) n++; end
    chk32("freq_no_resp", 32'(n), 32'd0);
    addr_delay = 0;

    // flush in WAIT
    data_delay = 3;
    send(1'b0, 3'd2, 32'h0000_6000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (resp_valid) n++; end
    chk32("fwait_no_resp", 32'(n), 32'd0);
    chk1("fwait_ready", req_ready, 1'b1);
    data_delay = 0;

    // reset while in WAIT, then a new LB
    data_delay = 5;
    send(1'b0, 3'd2, 32'h0000_7000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1 check_all_zero("rst_wait");
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    data_delay = 0;
    fixed_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    send(1'b0, 3'd0, 32'h0000_7003, 32'h0);
    @(negedge clk);
    chk1 ("lb_req",   data_req, 1'b1);
    chk1 ("lb_wr",    data_wr,  1'b0);
    chk32("lb_addr",  data_addr, 32'h0000_7003);
    chk32("lb_wstrb", 32'(data_wstrb), 32'h0);
    wait_resp("lb", 2, 1'b0, 32'hCAFE_F00D);

    // randomized traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 2) != 0);
      req_wr    = ($urandom_range(0, 1) == 1);
      req_op    = 3'($urandom_range(0, 7));
      req_addr  = $urandom;
      req_wdata = $urandom;
      flush     = ($urandom_range(0, 11) == 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk32("resp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_sram_ctrl.md
# data_sram_ctrl

Memory-stage load/store sequencer for the mipsel32 pipeline. It accepts one load or store per handshake from the EX/MEM boundary and derives the byte strobes, size and aligned address for sub-word, word and unaligned (LWL/LWR/SWL/SWR) accesses. It drives a single-outstanding SRAM-like data bus (`addr_ok`/`data_ok` two-phase handshake) and returns the raw read word to writeback. It also detects misaligned halfword/word addresses without touching the bus and discards in-flight responses on a pipeline flush.

## Interface
No parameters; data and address width fixed at 32.
- `clk`  in  1  clock, all state on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `req_valid`  in  1  pipeline presents an access
- `req_ready`  out  1  block accepts an access this cycle
- `req_wr`  in  1  1 = store, 0 = load
- `req_op`  in  3  000 byte, 001 half, 010 word, 011 LWL/SWL, 100 LWR/SWR; others illegal, treated as word
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  unshifted store data, from rt
- `flush`  in  1  exception/eret flush; kills un-issued and in-flight accesses
- `resp_valid`  out  1  one-cycle pulse: access complete
- `resp_rdata`  out  32  raw bus word for loads, 0 for stores
- `resp_ale`  out  1  address error (AdEL/AdES), qualifies `resp_valid`
- `data_req`  out  1  bus request
- `data_wr`  out  1  bus write
- `data_size`  out  2  0 byte, 1 half, 2 word
- `data_addr`  out  32  bus address
- `data_wstrb`  out  4  byte enables; 0 on reads
- `data_wdata`  out  32  lane-aligned store data
- `data_addr_ok`  in  1  request accepted by slave
- `data_rdata`  in  32  read data, valid with `data_data_ok`
- `data_data_ok`  in  1  transaction done

## Operation
- States: IDLE, REQ (data_req held), WAIT (addr accepted, awaiting data_ok).
- `req_ready = (state==IDLE) && !flush`. Accept = `req_valid && req_ready`.
- On accept, let k = `req_addr[1:0]`, and register the bus fields:
  - Byte: size 0, addr as given, wstrb `1<<k`, wdata `{4{b}}`.
  - Half: size 1, wstrb `0011` (k=0) or `1100` (k=2), wdata `{2{h}}`.
  - Word: size 2, wstrb `1111`.
  - LWL/SWL: size 2, addr `{a[31:2],00}`, wstrb `1111>>(3-k)`, wdata `req_wdata>>8*(3-k)`.
  - LWR/SWR: size 2, addr `{a[31:2],00}`, wstrb `1111<<k`, wdata `req_wdata<<8*k`.
  - Loads force wstrb 0.
- Misaligned access (half with a[0]=1, word with k≠0): go straight back to IDLE with no bus activity. `resp_valid=1`, `resp_ale=1` next cycle.
- Otherwise go to REQ.
- REQ:
  - `addr_ok` → WAIT.
  - `flush` without `addr_ok` → IDLE, request dropped, no response.
  - `flush` with `addr_ok` → WAIT with the discard flag set.
- WAIT:
  - `flush` sets the discard flag.
  - `data_ok` → IDLE, capturing `data_rdata` (loads).
  - `resp_valid` pulses the cycle after `data_ok` unless discard is set; discard clears on leaving WAIT.
- `data_ok` outside WAIT is ignored. Bus fields are stable while `data_req=1`.

## Timing
- Reset: state IDLE; `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata` all 0; `resp_valid`, `resp_ale`, `resp_rdata` all 0; discard flag 0.
- All outputs except `req_ready` are registered.
- Accept at edge T → `data_req` high in cycle T+1. With `addr_ok` in T+1 and `data_ok` in T+2, `resp_valid` is high in T+3 and `req_ready` is high again in T+3.
- Minimum back-to-back access period is 3 cycles. A misaligned access takes 1 cycle: response in T+1, ready again in T+1.
- `data_req` drops the cycle after `addr_ok` and never re-asserts before `data_ok`, giving at most one outstanding transaction.
- `flush` coincident with `req_valid` in IDLE: not accepted.
- `flush` in the same cycle as `data_ok`: response suppressed, state goes IDLE.
- `resetn` low mid-transaction clears state immediately. The bus slave is reset by the same signal.

## Test plan
- SB at addr 0x1002, wdata 0x000000AB; `addr_ok` immediate, `data_ok` +1 → `data_addr`=0x1002, size 0, wstrb 0100, wdata 0xABABABAB; `resp_valid` pulse with ale=0.
- SWL at 0x2001, wdata 0x11223344 → addr 0x2000, wstrb 0011, wdata 0x00001122. SWR at 0x2001 → wstrb 1110, wdata 0x22334400.
- LW at 0x3000 with `addr_ok` delayed 3 cycles and `data_rdata`=0xDEADBEEF → `data_req` held 4 cycles with stable fields; `resp_rdata`=0xDEADBEEF.
- LH at 0x4001 → no `data_req`; `resp_valid`=1 and `resp_ale`=1 the next cycle. SW at 0x4002 → same response.
- `flush` in REQ before `addr_ok` → `data_req` low next cycle, no response. `flush` in WAIT → `data_ok` consumed, no `resp_valid`, `req_ready` returns.
- `resetn` pulsed low while in WAIT → all outputs 0 immediately; a new LB is accepted after release.
